// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, op encodings and constants for machine_csr_unit
package csr_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MVENDORID      = 12'hF11;
    localparam logic [11:0] CSR_MARCHID        = 12'hF12;
    localparam logic [11:0] CSR_MIMPID         = 12'hF13;
    localparam logic [11:0] CSR_MHARTID        = 12'hF14;
    localparam logic [11:0] CSR_MCONFIGPTR     = 12'hF15;
    localparam logic [11:0] CSR_MSTATUS        = 12'h300;
    localparam logic [11:0] CSR_MISA           = 12'h301;
    localparam logic [11:0] CSR_MIE            = 12'h304;
    localparam logic [11:0] CSR_MTVEC          = 12'h305;
    localparam logic [11:0] CSR_MENVCFG        = 12'h30A;
    localparam logic [11:0] CSR_MSTATUSH       = 12'h310;
    localparam logic [11:0] CSR_MENVCFGH       = 12'h31A;
    localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3     = 12'h323;
    localparam logic [11:0] CSR_MHPMEVENT31    = 12'h33F;
    localparam logic [11:0] CSR_MSCRATCH       = 12'h340;
    localparam logic [11:0] CSR_MEPC           = 12'h341;
    localparam logic [11:0] CSR_MCAUSE         = 12'h342;
    localparam logic [11:0] CSR_MTVAL          = 12'h343;
    localparam logic [11:0] CSR_MIP            = 12'h344;
    localparam logic [11:0] CSR_MCYCLE         = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET       = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3   = 12'hB03;
    localparam logic [11:0] CSR_MHPMCOUNTER31  = 12'hB1F;
    localparam logic [11:0] CSR_MCYCLEH        = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH      = 12'hB82;
    localparam logic [11:0] CSR_MHPMCOUNTER3H  = 12'hB83;
    localparam logic [11:0] CSR_MHPMCOUNTER31H = 12'hB9F;

    localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
    localparam logic [4:0] IRQ_CODE_MTI = 5'd7;
    localparam logic [4:0] IRQ_CODE_MEI = 5'd11;

    // RV32I: MXL=1, extension I
    localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;
    // Machine-only hart: MPP is hardwired to M
    localparam logic [31:0] MSTATUS_MPP = 32'h0000_1800;

endpackage

// File: rtl/csr_counter.sv
// rtl/csr_counter.sv - wide event counter with split 32-bit write halves
module csr_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             increment,
    input  logic             inhibit,
    input  logic             write_low,
    input  logic             write_high,
    input  logic [31:0]      write_value,
    output logic [WIDTH-1:0] value
);

    // A write to either half takes the whole cycle; the untouched half holds
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (write_low || write_high) begin
            if (write_low)  value[31:0]       <= write_value;
            if (write_high) value[WIDTH-1:32] <= (WIDTH-32)'(write_value);
        end else if (increment && !inhibit) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/machine_csr_unit.sv
// rtl/machine_csr_unit.sv - machine-mode CSR file with traps, counters and interrupt arbitration
module machine_csr_unit
    import csr_pkg::*;
#(
    parameter int          NUM_HPM       = 4,
    parameter int          COUNTER_WIDTH = 64,
    parameter bit          VECTORED      = 1'b1,
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [11:0]                         address,
    input  logic [1:0]                          op,
    input  logic [31:0]                         write_value,
    output logic [31:0]                         read_value,
    output logic                                illegal,
    input  logic                                retire,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event,
    input  logic                                external_interrupt,
    input  logic                                timer_interrupt,
    input  logic                                software_interrupt,
    input  logic                                trap,
    input  logic                                trap_interrupt,
    input  logic [4:0]                          trap_code,
    input  logic [31:0]                         trap_pc,
    input  logic [31:0]                         trap_value,
    input  logic                                mret,
    output logic [31:0]                         trap_target,
    output logic [31:0]                         mepc_value,
    output logic                                interrupt_request,
    output logic [4:0]                          interrupt_code
);

    localparam int          HPM_W        = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] MTVEC_MASK   = {30'h3FFF_FFFF, 1'b0, VECTORED};
    localparam logic [31:0] INHIBIT_MASK = 32'h5 | 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);

    csr_op_e     op_e;
    logic        status_mie, status_mpie, status_mie_d, status_mpie_d;
    logic [2:0]  mie_q, mie_d, mip_bits, pending;   // {MEI, MTI, MSI}
    logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, inhibit_q;
    logic [31:0] new_value;
    logic        implemented, writes, do_write;
    logic [COUNTER_WIDTH-1:0] mcycle_value, minstret_value;
    logic [COUNTER_WIDTH-1:0] hpm_value [HPM_W];

    assign op_e       = csr_op_e'(op);
    assign mip_bits   = {external_interrupt, timer_interrupt, software_interrupt};
    assign mepc_value = mepc_q;
    assign trap_target = (mtvec_q[0] && trap_interrupt)
                       ? {mtvec_q[31:2], 2'b00} + {25'b0, trap_code, 2'b00}
                       : {mtvec_q[31:2], 2'b00};

    // Read mux; addresses not listed here are unimplemented
    always_comb begin
        read_value  = '0;
        implemented = 1'b1;
        case (address)
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID, CSR_MCONFIGPTR,
            CSR_MENVCFG, CSR_MENVCFGH, CSR_MSTATUSH: read_value = '0;
            CSR_MSTATUS:       read_value = MSTATUS_MPP | {24'b0, status_mpie, 3'b0, status_mie, 3'b0};
            CSR_MISA:          read_value = MISA_VALUE;
            CSR_MIE:           read_value = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
            CSR_MTVEC:         read_value = mtvec_q;
            CSR_MCOUNTINHIBIT: read_value = inhibit_q;
            CSR_MSCRATCH:      read_value = mscratch_q;
            CSR_MEPC:          read_value = mepc_q;
            CSR_MCAUSE:        read_value = mcause_q;
            CSR_MTVAL:         read_value = mtval_q;
            CSR_MIP:           read_value = {20'b0, mip_bits[2], 3'b0, mip_bits[1], 3'b0, mip_bits[0], 3'b0};
            CSR_MCYCLE:        read_value = mcycle_value[31:0];
            CSR_MCYCLEH:       read_value = 32'(mcycle_value >> 32);
            CSR_MINSTRET:      read_value = minstret_value[31:0];
            CSR_MINSTRETH:     read_value = 32'(minstret_value >> 32);
            default: begin
                if ((address >= CSR_MHPMEVENT3    && address <= CSR_MHPMEVENT31) ||
                    (address >= CSR_MHPMCOUNTER3  && address <= CSR_MHPMCOUNTER31) ||
                    (address >= CSR_MHPMCOUNTER3H && address <= CSR_MHPMCOUNTER31H)) begin
                    for (int i = 0; i < NUM_HPM; i++) begin
                        if (address == CSR_MHPMCOUNTER3 + 12'(i))  read_value = hpm_value[i][31:0];
                        if (address == CSR_MHPMCOUNTER3H + 12'(i)) read_value = 32'(hpm_value[i] >> 32);
                    end
                end else begin
                    implemented = 1'b0;
                end
            end
        endcase
    end

    // Read-modify-write data from the old value
    always_comb begin
        case (op_e)
            OP_SET:   new_value = read_value | write_value;
            OP_CLEAR: new_value = read_value & ~write_value;
            default:  new_value = write_value;
        endcase
    end

    // Set/clear with an empty mask is a pure read; trap and mret pre-empt any write
    assign writes   = (op_e == OP_WRITE) ||
                      ((op_e == OP_SET || op_e == OP_CLEAR) && write_value != 32'b0);
    assign illegal  = (op_e != OP_NONE) && (!implemented || (writes && address[11:10] == 2'b11));
    assign do_write = writes && !illegal && !trap && !mret;

    // Next state of the interrupt enables, shared with the arbiter
    always_comb begin
        status_mie_d  = status_mie;
        status_mpie_d = status_mpie;
        mie_d         = mie_q;
        if (trap) begin
            status_mpie_d = status_mie;
            status_mie_d  = 1'b0;
        end else if (mret) begin
            status_mie_d  = status_mpie;
            status_mpie_d = 1'b1;
        end else if (do_write && address == CSR_MSTATUS) begin
            status_mie_d  = new_value[3];
            status_mpie_d = new_value[7];
        end
        if (do_write && address == CSR_MIE) begin
            mie_d = {new_value[11], new_value[7], new_value[3]};
        end
    end

    // Architectural registers: trap entry, then CSR writes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            mie_q       <= '0;
            mtvec_q     <= RESET_VECTOR & 32'hFFFF_FFFC;
            mscratch_q  <= '0;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mtval_q     <= '0;
            inhibit_q   <= '0;
        end else begin
            status_mie  <= status_mie_d;
            status_mpie <= status_mpie_d;
            mie_q       <= mie_d;
            if (trap) begin
                mepc_q   <= trap_pc & 32'hFFFF_FFFC;
                mcause_q <= {trap_interrupt, 26'b0, trap_code};
                mtval_q  <= trap_value;
            end else if (do_write) begin
                case (address)
                    CSR_MTVEC:         mtvec_q    <= new_value & MTVEC_MASK;
                    CSR_MSCRATCH:      mscratch_q <= new_value;
                    CSR_MEPC:          mepc_q     <= new_value & 32'hFFFF_FFFC;
                    CSR_MCAUSE:        mcause_q   <= new_value & 32'h8000_001F;
                    CSR_MTVAL:         mtval_q    <= new_value;
                    CSR_MCOUNTINHIBIT: inhibit_q  <= new_value & INHIBIT_MASK;
                    default: ;
                endcase
            end
        end
    end

    // Arbitrate on next-state enables so the result tracks the register update edge
    assign pending = mip_bits & mie_d & {3{status_mie_d}};

    // Registered interrupt request: MEI > MSI > MTI
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            interrupt_request <= 1'b0;
            interrupt_code    <= '0;
        end else begin
            interrupt_request <= |pending;
            if (pending[2])      interrupt_code <= IRQ_CODE_MEI;
            else if (pending[0]) interrupt_code <= IRQ_CODE_MSI;
            else if (pending[1]) interrupt_code <= IRQ_CODE_MTI;
            else                 interrupt_code <= '0;
        end
    end

    csr_counter #(.WIDTH(COUNTER_WIDTH)) u_mcycle (
        .clock       (clock),
        .reset       (reset),
        .increment   (1'b1),
        .inhibit     (inhibit_q[0]),
        .write_low   (do_write && address == CSR_MCYCLE),
        .write_high  (do_write && address == CSR_MCYCLEH),
        .write_value (new_value),
        .value       (mcycle_value)
    );

    csr_counter #(.WIDTH(COUNTER_WIDTH)) u_minstret (
        .clock       (clock),
        .reset       (reset),
        .increment   (retire),
        .inhibit     (inhibit_q[2]),
        .write_low   (do_write && address == CSR_MINSTRET),
        .write_high  (do_write && address == CSR_MINSTRETH),
        .write_value (new_value),
        .value       (minstret_value)
    );

    if (NUM_HPM == 0) begin : g_no_hpm
        assign hpm_value[0] = '0;
    end
    for (genvar g = 0; g < NUM_HPM; g++) begin : g_hpm
        csr_counter #(.WIDTH(COUNTER_WIDTH)) u_counter (
            .clock       (clock),
            .reset       (reset),
            .increment   (hpm_event[g]),
            .inhibit     (inhibit_q[3+g]),
            .write_low   (do_write && address == CSR_MHPMCOUNTER3 + 12'(g)),
            .write_high  (do_write && address == CSR_MHPMCOUNTER3H + 12'(g)),
            .write_value (new_value),
            .value       (hpm_value[g])
        );
    end

endmodule

// File: tb/tb_machine_csr_unit.sv
// tb/tb_machine_csr_unit.sv - scoreboard bench for machine_csr_unit
module tb_machine_csr_unit;
    import csr_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] address = '0;
    logic [1:0]  op = '0;
    logic [31:0] write_value = '0;
    logic [31:0] read_value;
    logic        illegal;
    logic        retire = 1'b0;
    logic [3:0]  hpm_event = '0;
    logic        external_interrupt = 1'b0;
    logic        timer_interrupt = 1'b0;
    logic        software_interrupt = 1'b0;
    logic        trap = 1'b0;
    logic        trap_interrupt = 1'b0;
    logic [4:0]  trap_code = '0;
    logic [31:0] trap_pc = '0;
    logic [31:0] trap_value = '0;
    logic        mret = 1'b0;
    logic [31:0] trap_target;
    logic [31:0] mepc_value;
    logic        interrupt_request;
    logic [4:0]  interrupt_code;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp;

    machine_csr_unit #(
        .NUM_HPM(4), .COUNTER_WIDTH(33), .VECTORED(1'b1), .RESET_VECTOR(32'h0000_0103)
    ) dut (
        .clock(clock), .reset(reset), .address(address), .op(op), .write_value(write_value),
        .read_value(read_value), .illegal(illegal), .retire(retire), .hpm_event(hpm_event),
        .external_interrupt(external_interrupt), .timer_interrupt(timer_interrupt),
        .software_interrupt(software_interrupt), .trap(trap), .trap_interrupt(trap_interrupt),
        .trap_code(trap_code), .trap_pc(trap_pc), .trap_value(trap_value), .mret(mret),
        .trap_target(trap_target), .mepc_value(mepc_value),
        .interrupt_request(interrupt_request), .interrupt_code(interrupt_code)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // One CSR access spanning a single rising edge
    task automatic csr_access(input logic [11:0] a, input logic [1:0] o, input logic [31:0] v);
        @(negedge clock);
        address = a; op = o; write_value = v;
        @(posedge clock);
        #1;
        op = OP_NONE; write_value = '0;
    endtask

    task automatic peek(input logic [11:0] a);
        address = a; op = OP_NONE;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        exp_q.push_back(32'h0);
        checks++; exp = exp_q.pop_front();
        if ({31'b0, interrupt_request} !== exp) begin errors++; $display("FAIL reset_irq actual=%h required=%h", interrupt_request, exp); end
        exp_q.push_back(32'h0000_1800); peek(CSR_MSTATUS);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL reset_mstatus actual=%h required=%h", read_value, exp); end
        exp_q.push_back(32'h0000_0100); peek(CSR_MTVEC);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL reset_mtvec actual=%h required=%h", read_value, exp); end
        @(negedge clock);
        reset = 1'b0;
        exp_q.push_back(32'h4000_0100); peek(CSR_MISA);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL reset_misa actual=%h required=%h", read_value, exp); end
        exp_q.push_back(32'h0); peek(CSR_MSCRATCH);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL reset_mscratch actual=%h required=%h", read_value, exp); end
    endtask

    task automatic test_set_clear;
        csr_access(CSR_MSCRATCH, OP_WRITE, 32'hF0F0_0000);
        csr_access(CSR_MSCRATCH, OP_SET, 32'h0000_000F);
        exp_q.push_back(32'hF0F0_000F); peek(CSR_MSCRATCH);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL set_mscratch actual=%h required=%h", read_value, exp); end
        csr_access(CSR_MSCRATCH, OP_CLEAR, 32'hF000_0000);
        exp_q.push_back(32'h00F0_000F); peek(CSR_MSCRATCH);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL clear_mscratch actual=%h required=%h", read_value, exp); end
        address = CSR_MVENDORID; op = OP_SET; write_value = '0; #1;
        exp_q.push_back(32'h0);
        checks++; exp = exp_q.pop_front();
        if ({31'b0, illegal} !== exp) begin errors++; $display("FAIL set_zero_ro actual=%h required=%h", illegal, exp); end
        op = OP_NONE;
    endtask

    task automatic test_illegal;
        @(negedge clock);
        address = CSR_MVENDORID; op = OP_WRITE; write_value = 32'h5; #1;
        exp_q.push_back(32'h1);
        checks++; exp = exp_q.pop_front();
        if ({31'b0, illegal} !== exp) begin errors++; $display("FAIL write_ro actual=%h required=%h", illegal, exp); end
        @(posedge clock); #1;
        exp_q.push_back(32'h0); peek(CSR_MVENDORID);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL ro_unchanged actual=%h required=%h", read_value, exp); end
        exp_q.push_back(32'h0);
        checks++; exp = exp_q.pop_front();
        if ({31'b0, illegal} !== exp) begin errors++; $display("FAIL read_ro_legal actual=%h required=%h", illegal, exp); end
        @(negedge clock);
        address = 12'h7C0; op = OP_WRITE; write_value = 32'hFFFF_FFFF; #1;
        exp_q.push_back(32'h1);
        checks++; exp = exp_q.pop_front();
        if ({31'b0, illegal} !== exp) begin errors++; $display("FAIL unimpl actual=%h required=%h", illegal, exp); end
        @(posedge clock); #1;
        exp_q.push_back(32'h00F0_000F); peek(CSR_MSCRATCH);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL illegal_nostate actual=%h required=%h", read_value, exp); end
    endtask

    task automatic test_trap;
        csr_access(CSR_MTVEC, OP_WRITE, 32'h0000_1001);
        csr_access(CSR_MSTATUS, OP_WRITE, 32'h0000_0008);
        exp_q.push_back(32'h0000_1808); peek(CSR_MSTATUS);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL mstatus_mie actual=%h required=%h", read_value, exp); end
        @(negedge clock);
        trap = 1'b1; trap_interrupt = 1'b0; trap_code = 5'd7; trap_pc = 32'h203; trap_value = 32'hDEAD; #1;
        exp_q.push_back(32'h0000_1000);
        checks++; exp = exp_q.pop_front();
        if (trap_target !== exp) begin errors++; $display("FAIL target_exc actual=%h required=%h", trap_target, exp); end
        trap_interrupt = 1'b1; #1;
        exp_q.push_back(32'h0000_101C);
        checks++; exp = exp_q.pop_front();
        if (trap_target !== exp) begin errors++; $display("FAIL target_vec actual=%h required=%h", trap_target, exp); end
        @(posedge clock); #1;
        trap = 1'b0; trap_interrupt = 1'b0;
        exp_q.push_back(32'h0000_0200);
        checks++; exp = exp_q.pop_front();
        if (mepc_value !== exp) begin errors++; $display("FAIL trap_mepc actual=%h required=%h", mepc_value, exp); end
        exp_q.push_back(32'h8000_0007); peek(CSR_MCAUSE);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL trap_mcause actual=%h required=%h", read_value, exp); end
        exp_q.push_back(32'h0000_DEAD); peek(CSR_MTVAL);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL trap_mtval actual=%h required=%h", read_value, exp); end
        exp_q.push_back(32'h0000_1880); peek(CSR_MSTATUS);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL trap_mstatus actual=%h required=%h", read_value, exp); end
        @(negedge clock); mret = 1'b1;
        @(posedge clock); #1; mret = 1'b0;
        exp_q.push_back(32'h0000_1888); peek(CSR_MSTATUS);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL mret_mstatus actual=%h required=%h", read_value, exp); end
    endtask

    task automatic test_priority;
        @(negedge clock);
        trap = 1'b1; trap_interrupt = 1'b0; trap_code = 5'd2; trap_pc = 32'h300; trap_value = 32'h0;
        mret = 1'b1; address = CSR_MSCRATCH; op = OP_WRITE; write_value = 32'h1234;
        @(posedge clock); #1;
        trap = 1'b0; mret = 1'b0; op = OP_NONE;
        exp_q.push_back(32'h00F0_000F); peek(CSR_MSCRATCH);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL prio_mscratch actual=%h required=%h", read_value, exp); end
        exp_q.push_back(32'h0000_1880); peek(CSR_MSTATUS);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL prio_mstatus actual=%h required=%h", read_value, exp); end
        exp_q.push_back(32'h0000_0002); peek(CSR_MCAUSE);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL prio_mcause actual=%h required=%h", read_value, exp); end
    endtask

    task automatic test_counter_wrap;
        csr_access(CSR_MCYCLE, OP_WRITE, 32'hFFFF_FFFF);
        csr_access(CSR_MCYCLEH, OP_WRITE, 32'h1);
        exp_q.push_back(32'h1); peek(CSR_MCYCLEH);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL cycle_max_hi actual=%h required=%h", read_value, exp); end
        @(posedge clock); #1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        peek(CSR_MCYCLE);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL wrap_lo actual=%h required=%h", read_value, exp); end
        peek(CSR_MCYCLEH);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL wrap_hi actual=%h required=%h", read_value, exp); end
        csr_access(CSR_MCYCLE, OP_WRITE, 32'h100);
        exp_q.push_back(32'h100); peek(CSR_MCYCLE);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL write_wins actual=%h required=%h", read_value, exp); end
        @(posedge clock); #1;
        exp_q.push_back(32'h101); peek(CSR_MCYCLE);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL cycle_inc actual=%h required=%h", read_value, exp); end
    endtask

    task automatic test_inhibit;
        csr_access(CSR_MCOUNTINHIBIT, OP_WRITE, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_007D); peek(CSR_MCOUNTINHIBIT);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL inhibit_mask actual=%h required=%h", read_value, exp); end
        csr_access(CSR_MCOUNTINHIBIT, OP_WRITE, 32'h4);
        csr_access(CSR_MINSTRET, OP_WRITE, 32'h50);
        @(negedge clock); retire = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock); retire = 1'b0;
        exp_q.push_back(32'h50); peek(CSR_MINSTRET);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL instret_inhibited actual=%h required=%h", read_value, exp); end
        csr_access(CSR_MCOUNTINHIBIT, OP_WRITE, 32'h0);
        @(negedge clock); retire = 1'b1; hpm_event = 4'b0001;
        repeat (10) @(posedge clock);
        @(negedge clock); retire = 1'b0; hpm_event = 4'b0000;
        exp_q.push_back(32'h5A); peek(CSR_MINSTRET);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL instret_count actual=%h required=%h", read_value, exp); end
        exp_q.push_back(32'd10); peek(CSR_MHPMCOUNTER3);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL hpm3_count actual=%h required=%h", read_value, exp); end
        exp_q.push_back(32'd0); peek(12'hB04);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL hpm4_idle actual=%h required=%h", read_value, exp); end
    endtask

    task automatic test_interrupts;
        csr_access(CSR_MIE, OP_WRITE, 32'h0000_0888);
        csr_access(CSR_MSTATUS, OP_WRITE, 32'h0000_0008);
        @(negedge clock); timer_interrupt = 1'b1; external_interrupt = 1'b1;
        @(posedge clock); #1;
        exp_q.push_back({26'b0, 1'b1, IRQ_CODE_MEI});
        checks++; exp = exp_q.pop_front();
        if ({26'b0, interrupt_request, interrupt_code} !== exp) begin errors++; $display("FAIL irq_mei actual=%h required=%h", {interrupt_request, interrupt_code}, exp); end
        @(negedge clock); external_interrupt = 1'b0;
        @(posedge clock); #1;
        exp_q.push_back({26'b0, 1'b1, IRQ_CODE_MTI});
        checks++; exp = exp_q.pop_front();
        if ({26'b0, interrupt_request, interrupt_code} !== exp) begin errors++; $display("FAIL irq_mti actual=%h required=%h", {interrupt_request, interrupt_code}, exp); end
        @(negedge clock); software_interrupt = 1'b1;
        @(posedge clock); #1;
        exp_q.push_back({26'b0, 1'b1, IRQ_CODE_MSI});
        checks++; exp = exp_q.pop_front();
        if ({26'b0, interrupt_request, interrupt_code} !== exp) begin errors++; $display("FAIL irq_msi actual=%h required=%h", {interrupt_request, interrupt_code}, exp); end
        exp_q.push_back(32'h0000_0088); peek(CSR_MIP);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL mip_live actual=%h required=%h", read_value, exp); end
        @(negedge clock); trap = 1'b1; trap_interrupt = 1'b1; trap_code = IRQ_CODE_MSI; trap_pc = 32'h400;
        @(posedge clock); #1; trap = 1'b0; trap_interrupt = 1'b0;
        exp_q.push_back(32'h0);
        checks++; exp = exp_q.pop_front();
        if ({31'b0, interrupt_request} !== exp) begin errors++; $display("FAIL irq_trap_drop actual=%h required=%h", interrupt_request, exp); end
        csr_access(CSR_MSTATUS, OP_SET, 32'h0000_0008);
        @(posedge clock); #1;
        exp_q.push_back({26'b0, 1'b1, IRQ_CODE_MSI});
        checks++; exp = exp_q.pop_front();
        if ({26'b0, interrupt_request, interrupt_code} !== exp) begin errors++; $display("FAIL irq_reenable actual=%h required=%h", {interrupt_request, interrupt_code}, exp); end
        @(negedge clock); #2;
        address = CSR_MSCRATCH; op = OP_WRITE; write_value = 32'h55;
        reset = 1'b1; #1;
        exp_q.push_back(32'h0);
        checks++; exp = exp_q.pop_front();
        if ({26'b0, interrupt_request, interrupt_code} !== exp) begin errors++; $display("FAIL irq_async_reset actual=%h required=%h", {interrupt_request, interrupt_code}, exp); end
        repeat (2) @(posedge clock);
        @(negedge clock); op = OP_NONE; reset = 1'b0;
        exp_q.push_back(32'h0); peek(CSR_MSCRATCH);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL reset_drops_write actual=%h required=%h", read_value, exp); end
        exp_q.push_back(32'h0); peek(CSR_MIE);
        checks++; exp = exp_q.pop_front();
        if (read_value !== exp) begin errors++; $display("FAIL reset_mie actual=%h required=%h", read_value, exp); end
    endtask

    initial begin
        test_reset();
        test_set_clear();
        test_illegal();
        test_trap();
        test_priority();
        test_counter_wrap();
        test_inhibit();
        test_interrupts();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
